// File: rtl/mask_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mask_pkg
// Description : Shared types and defaults for the mask pipeline (sync
//               controller, frame controller, mask generator).
// Revision    : 1.0 - initial release
// ============================================================================
package mask_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SOF = 3'd1,
    RUN      = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } frame_state_e;

  localparam int          H_ACTIVE_DEF    = 640;
  localparam int          V_ACTIVE_DEF    = 480;
  localparam int          CNT_W_DEF       = 20;
  localparam logic [31:0] THR_DEFAULT_DEF = 32'd300;

endpackage : mask_pkg
`default_nettype wire

// File: rtl/mask_fg_counter.sv
`default_nettype none
// ============================================================================
// Module      : mask_fg_counter
// Description : Saturating foreground-pixel counter with synchronous clear.
//               Exposes the next-state value so a frame's final count
//               (including a pixel counted this cycle) can be captured.
// Revision    : 1.0 - initial release
// ============================================================================
module mask_fg_counter #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count_next
);

  logic [CNT_W-1:0] count_q;

  // Next count: clear wins over increment; increment stops at all-ones
  always_comb begin
    count_next = count_q;
    if (clear) begin
      count_next = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_next = count_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_next;
    end
  end

endmodule : mask_fg_counter
`default_nettype wire

// File: rtl/mask_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mask_frame_ctrl
// Description : Frame-level sequencer for the mask generator. Gates pixel
//               reads on whole-frame boundaries, applies threshold updates
//               only at start of frame, and reports a per-frame foreground
//               count with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mask_frame_ctrl
  import mask_pkg::*;
#(
  parameter int          H_ACTIVE    = H_ACTIVE_DEF,
  parameter int          V_ACTIVE    = V_ACTIVE_DEF,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter logic [31:0] THR_DEFAULT = THR_DEFAULT_DEF
) (
  input  logic             clk_25,
  input  logic             rst,
  input  logic             enable,
  input  logic             single,
  input  logic [31:0]      thr_in,
  input  logic             thr_load,
  input  logic             pix_valid,
  input  logic [9:0]       sync_x,
  input  logic [9:0]       sync_y,
  output logic             read,
  output logic [31:0]      threshold,
  input  logic             mask_valid,
  input  logic             mask,
  input  logic [9:0]       mask_x,
  input  logic [9:0]       mask_y,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] fg_count
);

  localparam logic [9:0] c_x_last = 10'(H_ACTIVE - 1);
  localparam logic [9:0] c_y_last = 10'(V_ACTIVE - 1);

  frame_state_e     state_q, state_d;
  logic [31:0]      threshold_q, threshold_d;
  logic [31:0]      pending_q, pending_d;
  logic             pend_flag_q, pend_flag_d;
  logic             single_q, single_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] fg_count_q, fg_count_d;

  logic             w_sof;
  logic             w_last;
  logic             w_pix_last;
  logic             w_sof_accept;
  logic             w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_next;

  // Frame boundary detection on the pixel stream and the mask result stream
  always_comb begin
    w_sof      = pix_valid && (sync_x == 10'd0) && (sync_y == 10'd0);
    w_pix_last = pix_valid && (sync_x == c_x_last) && (sync_y == c_y_last);
    w_last     = mask_valid && (mask_x == c_x_last) && (mask_y == c_y_last);
    w_cnt_inc  = ((state_q == RUN) || (state_q == DRAIN)) && mask_valid && !mask;
  end

  // Sequencer next-state, read gating, SOF-aligned threshold and count capture
  always_comb begin
    state_d      = state_q;
    threshold_d  = threshold_q;
    pending_d    = pending_q;
    pend_flag_d  = pend_flag_q;
    single_d     = single_q;
    fg_count_d   = fg_count_q;
    w_sof_accept = 1'b0;
    read         = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (w_sof) begin
          state_d      = RUN;
          w_sof_accept = 1'b1;
          read         = 1'b1;
        end
      end
      RUN: begin
        read = pix_valid;
        if (w_last) begin
          state_d    = DONE;
          fg_count_d = w_cnt_next;
        end else if (w_sof) begin
          // Frame lost pixels: restart on the new frame without reporting
          w_sof_accept = 1'b1;
        end else if (w_pix_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (w_last) begin
          state_d    = DONE;
          fg_count_d = w_cnt_next;
        end
      end
      DONE: begin
        state_d = (enable && !single_q) ? WAIT_SOF : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pending value is consumed before a same-cycle load overwrites it
    if (w_sof_accept) begin
      single_d = single;
      if (pend_flag_q) begin
        threshold_d = pending_q;
        pend_flag_d = 1'b0;
      end
    end
    if (thr_load) begin
      pending_d   = thr_in;
      pend_flag_d = 1'b1;
    end

    frame_done_d = (state_d == DONE);
    busy_d       = (state_d == WAIT_SOF) || (state_d == RUN) || (state_d == DRAIN);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q      <= IDLE;
      threshold_q  <= THR_DEFAULT;
      pending_q    <= THR_DEFAULT;
      pend_flag_q  <= 1'b0;
      single_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      fg_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      threshold_q  <= threshold_d;
      pending_q    <= pending_d;
      pend_flag_q  <= pend_flag_d;
      single_q     <= single_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      fg_count_q   <= fg_count_d;
    end
  end

  mask_fg_counter #(
    .CNT_W (CNT_W)
  ) u_fg_counter (
    .clk        (clk_25),
    .rst        (rst),
    .clear      (w_sof_accept),
    .inc        (w_cnt_inc),
    .count_next (w_cnt_next)
  );

  assign threshold  = threshold_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign fg_count   = fg_count_q;

endmodule : mask_frame_ctrl
`default_nettype wire

// File: tb/tb_mask_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mask_frame_ctrl
// Description : Self-checking bench for mask_frame_ctrl on a reduced 16x8
//               frame with a 6-bit foreground counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mask_frame_ctrl;

  localparam int H_T   = 16;
  localparam int V_T   = 8;
  localparam int N_PIX = H_T * V_T;
  localparam int CW    = 6;

  logic          clk_25 = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          single = 1'b0;
  logic [31:0]   thr_in = 32'd0;
  logic          thr_load = 1'b0;
  logic          pix_valid = 1'b0;
  logic [9:0]    sync_x = '0;
  logic [9:0]    sync_y = '0;
  logic          read;
  logic [31:0]   threshold;
  logic          mask_valid;
  logic          mask;
  logic [9:0]    mask_x;
  logic [9:0]    mask_y;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] fg_count;

  int checks = 0;
  int errors = 0;
  int pat = 0;

  int done_cnt = 0;
  int fg_last = 0;
  int busy_after = -1;
  int read_cnt = 0;
  logic done_prev = 1'b0;

  mask_frame_ctrl #(
    .H_ACTIVE (H_T),
    .V_ACTIVE (V_T),
    .CNT_W    (CW)
  ) dut (
    .clk_25     (clk_25),
    .rst        (rst),
    .enable     (enable),
    .single     (single),
    .thr_in     (thr_in),
    .thr_load   (thr_load),
    .pix_valid  (pix_valid),
    .sync_x     (sync_x),
    .sync_y     (sync_y),
    .read       (read),
    .threshold  (threshold),
    .mask_valid (mask_valid),
    .mask       (mask),
    .mask_x     (mask_x),
    .mask_y     (mask_y),
    .busy       (busy),
    .frame_done (frame_done),
    .fg_count   (fg_count)
  );

  always #5 clk_25 = ~clk_25;

  // Pattern 0: every 4th pixel foreground; 1: all foreground; 2: none
  function automatic logic mask_of(input int x, input int y);
    if (pat == 0) return (((y * H_T) + x) % 4) != 0;
    if (pat == 1) return 1'b0;
    return 1'b1;
  endfunction

  // One-cycle-latency mask generator model
  always @(posedge clk_25) begin
    if (rst) begin
      mask_valid <= 1'b0;
    end else begin
      mask_valid <= read;
    end
    mask_x <= sync_x;
    mask_y <= sync_y;
    mask   <= mask_of(int'(sync_x), int'(sync_y));
  end

  // Event monitor, sampled mid-cycle
  always @(negedge clk_25) begin
    if (done_prev) busy_after = int'(busy);
    done_prev = frame_done;
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      fg_last  = int'(fg_count);
    end
    if (read) read_cnt = read_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic pixel(input int x, input int y);
    pix_valid = 1'b1;
    sync_x    = 10'(x);
    sync_y    = 10'(y);
    @(posedge clk_25);
    #1;
    thr_load = 1'b0;
  endtask

  task automatic blank(input int n);
    pix_valid = 1'b0;
    repeat (n) begin
      @(posedge clk_25);
      #1;
    end
    thr_load = 1'b0;
  endtask

  task automatic pixels(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      pixel((start + i) % H_T, (start + i) / H_T);
    end
  endtask

  typedef struct {
    logic sgl;
    int   pat;
    int   exp_fg;
    int   exp_done;
    int   exp_busy;
  } frame_vec_t;

  frame_vec_t vecs[4];

  initial begin
    int d0;
    int r0;

    vecs[0] = '{sgl: 1'b0, pat: 0, exp_fg: 32, exp_done: 1, exp_busy: 1};
    vecs[1] = '{sgl: 1'b0, pat: 2, exp_fg: 0,  exp_done: 1, exp_busy: 1};
    vecs[2] = '{sgl: 1'b0, pat: 1, exp_fg: 63, exp_done: 1, exp_busy: 1};
    vecs[3] = '{sgl: 1'b1, pat: 0, exp_fg: 32, exp_done: 1, exp_busy: 0};

    // Reset state
    rst = 1'b1;
    blank(3);
    chk("reset_read", int'(read), 0);
    chk("reset_threshold", int'(threshold), 300);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_fg_count", int'(fg_count), 0);
    rst = 1'b0;

    // Table-driven whole frames
    enable = 1'b1;
    blank(2);
    for (int v = 0; v < 4; v++) begin
      single     = vecs[v].sgl;
      pat        = vecs[v].pat;
      d0         = done_cnt;
      busy_after = -1;
      pixels(0, N_PIX);
      single = 1'b0;
      blank(4);
      chk($sformatf("vec%0d_done", v), done_cnt - d0, vecs[v].exp_done);
      chk($sformatf("vec%0d_fg_count", v), fg_last, vecs[v].exp_fg);
      chk($sformatf("vec%0d_busy_after", v), busy_after, vecs[v].exp_busy);
    end

    // Threshold loaded mid-frame waits for the next SOF
    pat = 0;
    d0  = done_cnt;
    pixels(0, 40);
    thr_in   = 32'd500;
    thr_load = 1'b1;
    pixels(40, N_PIX - 40);
    blank(4);
    chk("thr_hold_midframe", int'(threshold), 300);
    chk("thr_frame_done", done_cnt - d0, 1);

    // Load on the SOF cycle: older pending value applies now
    pix_valid = 1'b1;
    sync_x    = 10'd0;
    sync_y    = 10'd0;
    thr_in    = 32'd700;
    thr_load  = 1'b1;
    #1;
    chk("sof_read", int'(read), 1);
    chk("thr_before_sof_edge", int'(threshold), 300);
    @(posedge clk_25);
    #1;
    thr_load = 1'b0;
    chk("thr_after_sof", int'(threshold), 500);
    pixels(1, N_PIX - 1);
    blank(4);
    chk("thr_frame_end", int'(threshold), 500);
    pixels(0, 1);
    chk("thr_next_sof", int'(threshold), 700);
    pixels(1, N_PIX - 1);
    blank(4);

    // Mid-frame enable waits for the next frame
    enable = 1'b0;
    blank(4);
    r0     = read_cnt;
    enable = 1'b1;
    pixels(3 * H_T + 5, N_PIX - (3 * H_T + 5));
    blank(4);
    chk("midframe_enable_reads", read_cnt - r0, 0);

    // Enable dropped mid-frame: frame still completes, then idle
    r0         = read_cnt;
    d0         = done_cnt;
    busy_after = -1;
    pixels(0, 20);
    enable = 1'b0;
    pixels(20, N_PIX - 20);
    blank(4);
    chk("drop_enable_reads", read_cnt - r0, N_PIX);
    chk("drop_enable_done", done_cnt - d0, 1);
    chk("drop_enable_busy_after", busy_after, 0);
    r0 = read_cnt;
    pixels(0, N_PIX);
    blank(2);
    chk("disabled_frame_reads", read_cnt - r0, 0);

    // Second SOF before last: counter restarts, no done for the lost frame
    enable = 1'b1;
    blank(2);
    pat = 0;
    d0  = done_cnt;
    pixels(0, 50);
    chk("restart_no_done", done_cnt - d0, 0);
    pixels(0, N_PIX);
    blank(4);
    chk("restart_done", done_cnt - d0, 1);
    chk("restart_fg_count", fg_last, 32);

    // Reset in RUN
    d0 = done_cnt;
    pixels(0, 30);
    rst = 1'b1;
    pixel(30 % H_T, 30 / H_T);
    chk("rst_run_read", int'(read), 0);
    chk("rst_run_threshold", int'(threshold), 300);
    chk("rst_run_fg_count", int'(fg_count), 0);
    chk("rst_run_busy", int'(busy), 0);
    chk("rst_run_frame_done", int'(frame_done), 0);
    rst = 1'b0;
    blank(3);
    chk("rst_run_no_done", done_cnt - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mask_frame_ctrl
`default_nettype wire
